// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the gated frequency meter.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2
   } state_t;

   localparam int GATE_CYCLES_DEFAULT = 50_000_000;
   localparam int GATE_W_DEFAULT      = 26;
   localparam int RES_W_DEFAULT       = 26;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a
// previous-value flop; edge_strb pulses for one clk when the
// synchronized input goes from 0 to 1.
module sig_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic edge_strb
);

   logic sync1;
   logic sync2;
   logic prev;

   // Resynchronize d into the clk domain and keep one cycle of history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= d;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign edge_strb = sync2 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a window of
// GATE_CYCLES clk cycles and publishes the count with a one-cycle strobe.
// Windows run back to back while en stays high; dropping en aborts the
// window in progress without publishing.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
   parameter int GATE_W      = GATE_W_DEFAULT,
   parameter int RES_W       = RES_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [RES_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow,
   output logic             busy
);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [RES_W-1:0]  RES_MAX   = {RES_W{1'b1}};

   state_t            state;
   logic              arm_cnt;
   logic [GATE_W-1:0] gate_cnt;
   logic [RES_W-1:0]  edge_cnt;
   logic              sat;
   logic              edge_strb;
   logic              hit_sat;
   logic              window_end;
   logic [RES_W-1:0]  cnt_next;

   sig_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .d         (sig_in),
      .edge_strb (edge_strb)
   );

   // Saturating increment: an edge arriving at full scale is dropped and
   // remembered as an overflow so the published count is flagged inexact.
   always_comb begin
      hit_sat    = edge_strb & (edge_cnt == RES_MAX);
      window_end = (gate_cnt == GATE_LAST);
      cnt_next   = edge_cnt;
      if (!hit_sat) begin
         cnt_next = edge_cnt + RES_W'(edge_strb);
      end
   end

   // Control FSM with gate counter, edge counter and result registers.
   // ARM waits two cycles so the synchronizer holds fresh data before the
   // first counted cycle; a window end takes priority over an abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         arm_cnt    <= 1'b0;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
         freq       <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         case (state)
            IDLE: begin
               arm_cnt <= 1'b0;
               if (en) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               if (!en) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  arm_cnt <= 1'b0;
               end else if (arm_cnt) begin
                  state   <= GATE;
                  arm_cnt <= 1'b0;
               end else begin
                  arm_cnt <= 1'b1;
               end
            end
            GATE: begin
               if (window_end) begin
                  freq       <= cnt_next;
                  overflow   <= sat | hit_sat;
                  freq_valid <= 1'b1;
                  gate_cnt   <= '0;
                  edge_cnt   <= '0;
                  sat        <= 1'b0;
                  if (!en) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (!en) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GATE_W'(1);
                  edge_cnt <= cnt_next;
                  sat      <= sat | hit_sat;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle window and a 4-bit
// result so saturation is reachable quickly.
module tb_freq_meter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       sig_in;
   logic [3:0] freq;
   logic       freq_valid;
   logic       overflow;
   logic       busy;

   typedef struct {
      int         c;
      logic [3:0] f;
      logic       o;
   } pulse_t;

   pulse_t pq[$];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   e     = 0;
   int   per   = 0;
   int   hi    = 0;
   int   org   = 0;
   logic lvl   = 1'b0;

   freq_meter #(
      .GATE_CYCLES (100),
      .GATE_W      (7),
      .RES_W       (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sig_in     (sig_in),
      .freq       (freq),
      .freq_valid (freq_valid),
      .overflow   (overflow),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index used to timestamp freq_valid pulses.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic driveSig();
      if (per == 0) sig_in = lvl;
      else sig_in = ((((cyc - org) % per) + per) % per) < hi;
   endtask

   // Advance n cycles: sample at the falling edge, log pulses, drive sig_in.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (freq_valid) pq.push_back('{cyc - e, freq, overflow});
         driveSig();
      end
   endtask

   task automatic startRun(input int p, input int h, input int off, input logic l);
      per = p;
      hi  = h;
      lvl = l;
      e   = cyc;
      org = e + off;
      pq.delete();
      en  = 1'b1;
      driveSig();
   endtask

   task automatic checkPulse(input string tag, input int idx, input int exp_c,
                             input int exp_f, input logic exp_o);
      if (pq.size() > idx) begin
         checkOutput({tag, "_cyc"}, pq[idx].c, exp_c);
         checkOutput({tag, "_freq"}, {28'd0, pq[idx].f}, exp_f);
         checkOutput({tag, "_ovf"}, {31'd0, pq[idx].o}, {31'd0, exp_o});
      end else begin
         checkOutput({tag, "_missing"}, pq.size(), idx + 1);
      end
   endtask

   initial begin
      rst    = 1'b0;
      en     = 1'b0;
      sig_in = 1'b0;
      applyStimulus(3);
      $display("[TB] reset state");
      checkOutput("rst_freq", {28'd0, freq}, 0);
      checkOutput("rst_valid", {31'd0, freq_valid}, 0);
      checkOutput("rst_ovf", {31'd0, overflow}, 0);
      checkOutput("rst_busy", {31'd0, busy}, 0);
      rst = 1'b1;
      applyStimulus(2);

      $display("[TB] idle with toggling input");
      per = 10; hi = 5; org = cyc;
      pq.delete();
      applyStimulus(150);
      checkOutput("idle_pulses", pq.size(), 0);
      checkOutput("idle_busy", {31'd0, busy}, 0);

      $display("[TB] exact count, edges on gate_cnt 9..99");
      startRun(10, 5, 0, 1'b0);
      checkOutput("busy_pre", {31'd0, busy}, 0);
      applyStimulus(1);
      checkOutput("busy_armed", {31'd0, busy}, 1);
      applyStimulus(309);
      checkOutput("exact_npulses", pq.size(), 3);
      checkPulse("exact0", 0, 103, 10, 1'b0);
      checkPulse("exact1", 1, 203, 10, 1'b0);
      checkPulse("exact2", 2, 303, 10, 1'b0);
      en = 1'b0;
      applyStimulus(10);

      $display("[TB] boundary, edges on gate_cnt 0..90");
      startRun(10, 5, 1, 1'b0);
      applyStimulus(210);
      checkPulse("bnd0", 0, 103, 10, 1'b0);
      checkPulse("bnd1", 1, 203, 10, 1'b0);
      en = 1'b0;
      applyStimulus(10);

      $display("[TB] saturation then recovery");
      startRun(4, 2, 0, 1'b0);
      applyStimulus(210);
      checkPulse("sat0", 0, 103, 15, 1'b1);
      checkPulse("sat1", 1, 203, 15, 1'b1);
      per = 20; hi = 10; org = cyc;
      applyStimulus(200);
      checkPulse("slow3", 3, 403, 5, 1'b0);
      en = 1'b0;
      applyStimulus(10);

      $display("[TB] abort at gate_cnt 50");
      startRun(4, 2, 0, 1'b0);
      applyStimulus(53);
      checkOutput("abort_busy_before", {31'd0, busy}, 1);
      en = 1'b0;
      applyStimulus(1);
      checkOutput("abort_busy_after", {31'd0, busy}, 0);
      applyStimulus(150);
      checkOutput("abort_pulses", pq.size(), 0);
      checkOutput("abort_freq_kept", {28'd0, freq}, 5);
      checkOutput("abort_ovf_kept", {31'd0, overflow}, 0);
      startRun(10, 5, 3, 1'b0);
      applyStimulus(110);
      checkPulse("rearm", 0, 103, 10, 1'b0);
      en = 1'b0;
      applyStimulus(10);

      $display("[TB] single slow pulse");
      startRun(0, 0, 0, 1'b0);
      applyStimulus(40);
      lvl = 1'b1;
      applyStimulus(5);
      lvl = 1'b0;
      applyStimulus(70);
      checkPulse("single", 0, 103, 1, 1'b0);
      en = 1'b0;
      lvl = 1'b1;
      applyStimulus(10);
      startRun(0, 0, 0, 1'b1);
      applyStimulus(110);
      checkPulse("held_high", 0, 103, 0, 1'b0);
      en = 1'b0;
      applyStimulus(10);

      $display("[TB] asynchronous reset mid-window");
      startRun(4, 2, 0, 1'b0);
      applyStimulus(150);
      checkPulse("pre_rst", 0, 103, 15, 1'b1);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_freq", {28'd0, freq}, 0);
      checkOutput("mid_rst_ovf", {31'd0, overflow}, 0);
      checkOutput("mid_rst_busy", {31'd0, busy}, 0);
      checkOutput("mid_rst_valid", {31'd0, freq_valid}, 0);
      en = 1'b0;
      pq.delete();
      applyStimulus(5);
      rst = 1'b1;
      applyStimulus(150);
      checkOutput("post_rst_pulses", pq.size(), 0);
      checkOutput("post_rst_freq", {28'd0, freq}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency meter: the measuring end of the slow-clock chain. It counts rising edges of an asynchronous input (e.g. a divider output or external pulse source) over a fixed window of GATE_CYCLES system clocks, then publishes the count. With the default 50 MHz window, the published value is the input frequency in Hz. The scoreboard logic uses it to self-check its divided timebases.

## Interface
- GATE_CYCLES, 50_000_000: window length in clk cycles; must be ≥ 4.
- GATE_W, 26: gate counter width; must satisfy 2^GATE_W > GATE_CYCLES-1.
- RES_W, 26: edge counter and result width.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable, synchronous to clk.
- sig_in  in  1  measured signal; asynchronous to clk.
- freq  out  RES_W  edge count of the last completed window.
- freq_valid  out  1  one-cycle pulse when freq updates.
- overflow  out  1  last completed window saturated the edge counter.
- busy  out  1  high while a window is in progress.

## Operation
- Input path: 2-flop synchronizer, then a previous-value flop.
  - edge = sync & ~prev.
  - On reset, all three flops are 0.
- States:
  - IDLE: default.
  - ARM: 2 cycles, refills the synchronizer so stale data is never counted.
  - GATE: window in progress.
- Transitions:
  - IDLE→ARM when en=1.
  - ARM→GATE after 2 cycles in ARM.
  - GATE→GATE on window end if en=1 (contiguous windows, no dead cycle).
  - GATE→IDLE on window end if en=0.
  - en=0 in ARM or GATE: abort to IDLE next cycle. No result is published; edge and gate counters clear.
- GATE: gate_cnt counts 0..GATE_CYCLES-1. edge_cnt += edge, saturating at 2^RES_W-1.
- Window end (gate_cnt == GATE_CYCLES-1):
  - freq ← edge_cnt + edge (saturating).
  - overflow ← saturation reached in this window, including this final cycle.
  - freq_valid=1 for exactly that one registered cycle.
  - gate_cnt ← 0, edge_cnt ← 0.
- Counting is exact when the sig_in high and low phases each last ≥ 2 clk cycles. Faster inputs are undefined (aliasing); no detection is required.
- freq and overflow hold their value until the next window end. An abort does not clear them.
- busy = (state == ARM or GATE).

## Timing
- Reset values:
  - freq=0, freq_valid=0, overflow=0, busy=0.
  - state=IDLE, gate_cnt=0, edge_cnt=0, synchronizer=0.
- Latency from a sig_in rise to the edge strobe: 3 clk cycles (2 sync + 1 prev).
- en rises at cycle t: busy=1 from t+1. The first GATE cycle is t+3.
- First freq_valid: t+3+GATE_CYCLES. With en held high, later pulses follow every GATE_CYCLES cycles.
- An edge strobe in the window's final cycle counts in that window. An edge strobe in the next cycle counts in the next window. No edge is lost or double-counted across the window boundary.
- Asynchronous reset mid-window: all state returns to reset values immediately. Reset release is synchronous to clk.

## Structure
- Package freq_meter_pkg:
  - state enum {IDLE, ARM, GATE}.
  - Default constants: GATE_CYCLES_DEFAULT=50_000_000, GATE_W_DEFAULT=26, RES_W_DEFAULT=26.
- One sub-module, sig_sync_edge: 2-flop synchronizer plus rising-edge strobe. Ports: clk, rst, d, edge. Reused by other asynchronous inputs (buttons, buzzer feedback).
- The top level holds the FSM, gate counter, saturating edge counter and result registers.

## Test plan
- Reset/idle: assert rst mid-window with GATE_CYCLES=100 → all outputs 0 immediately; no freq_valid while en=0.
- Exact count: GATE_CYCLES=100, sig_in period 10 clk (5 high/5 low), en held high → freq=10 on every pulse; pulses 100 cycles apart; first pulse 103 cycles after en rises.
- Boundary edge: place an edge strobe exactly on gate_cnt=99, then the next one on gate_cnt=0 of the following window → counted once in each window; freq unchanged vs. the period-aligned case.
- Saturation: RES_W=4, GATE_CYCLES=100, sig_in period 4 clk → freq=15, overflow=1. Then slow sig_in to period 20 → next result freq=5, overflow=0.
- Abort: drop en at gate_cnt=50 → busy=0 the next cycle; no freq_valid; freq retains the prior value. Re-enable → a full fresh window, correct count.
- Slow input: sig_in constant 0, then a single pulse 5 clk wide mid-window → freq=1. The following window with sig_in held high gives freq=0.
